pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register for the next-generation pipeline.
- Replaces the fixed per-stage register blocks with a single flat payload vector plus a valid/ready handshake, synchronous flush, occupancy reporting and a saturating stall counter.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage instance packs its own fields into the payload.

Parameters:
- DATA_W, 256: payload width in bits (pc, instruction, decoded fields, control word, operands packed by the instantiating stage).
- CNT_W, 16: stall counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; kills all held entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  entry presented downstream.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  payload of the head entry.
- occupancy  output  2  number of held entries (0..2).
- clr_stats  input  1  synchronous clear of stall_cnt.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - All valid bits 0, all payload registers 0, stall_cnt 0.
  - Outputs: out_valid=0, out_data=0, occupancy=0.
  - in_ready=1 while rst=1 with no held entries; its value while rst=0 is don't-care.
- Handshakes:
  - Accept when in_valid & in_ready.
  - Emit when out_valid & out_ready.
  - in_data is sampled only on accept. out_data is stable while out_valid=1 and out_ready=0.
  - Strict FIFO order; no entry is duplicated or dropped except by flush.
- Latency: an accepted entry appears on out_valid/out_data the cycle after acceptance at the earliest. No combinational in-to-out path.
- Throughput: one entry per cycle sustained when out_ready=1 continuously.
- Head register (main) drives out_data/out_valid directly from flops.
- Flush:
  - flush=1 at an edge clears every valid bit; occupancy=0 next cycle.
  - An entry accepted in the same cycle is discarded.
  - An entry emitted in the same cycle still counts as transferred downstream.
  - Payload registers are not cleared by flush; out_data is don't-care while out_valid=0.
  - flush has priority over every other update except reset.
- Occupancy: equals the registered count of valid entries; it is not a combinational function of in/out handshakes.
- stall_cnt:
  - Increments by 1 each cycle with out_valid=1 and out_ready=0, including flush cycles.
  - Holds at all-ones.
  - clr_stats=1 sets it to 0 next cycle; clr_stats wins over increment.
- Reset mid-transfer: all state is lost immediately. The first cycle after rst deasserts behaves as the post-reset empty state.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined (two entries, main + skid):
  - in_ready = !skid_valid, driven from a flop with no combinational dependence on out_ready.
  - Accept while main is valid and not emitting: entry goes to skid.
  - Emit with skid valid: skid moves to main, and a simultaneous accept goes to skid.
  - Emit with skid empty: a simultaneous accept goes to main.
  - occupancy ranges 0..2.
- Undefined (single entry):
  - in_ready = !main_valid | out_ready, combinational.
  - Skid register absent; occupancy ranges 0..1 with bit 1 tied 0.
- Handshake semantics, latency, flush and stall_cnt behaviour are identical in both builds.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1, in_data=0xA5.. → out_valid=0, out_data=0, occupancy=0, stall_cnt=0. First accept after release emits 0xA5.. one cycle later.
- Streaming: out_ready=1, feed 8 back-to-back entries 1..8 → out_data 1..8 on 8 consecutive cycles, starting 1 cycle after the first accept. in_ready stays 1 throughout.
- Backpressure:
  - out_ready=0 for 4 cycles while sending entries 0x10, 0x11, 0x12.
  - SKID build: 0x10 and 0x11 held, in_ready=0, occupancy=2. Non-SKID build: 0x10 held, occupancy=1.
  - stall_cnt=4 after the window.
  - Release → remaining entries emitted in order, no loss.
- Flush with simultaneous accept: occupancy=2, flush=1 and in_valid=1 with 0x55 → next cycle occupancy=0, out_valid=0. 0x55 is never emitted.
- Counter: with CNT_W=4, stall 20 cycles → stall_cnt=15. Assert clr_stats together with a further stall → stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg
// ----------------------------------------------------------------------------
// Generic pipeline stage register. It sits between any two pipeline stages
// (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries one flat payload vector that the
// instantiating stage packs with its own fields. It provides a valid/ready
// handshake, a synchronous flush, occupancy reporting and a saturating stall
// counter.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> two entries (main + skid). in_ready comes
//                                    straight from a flop, so it does not
//                                    depend on out_ready.
//                       undefined -> single entry (main only). in_ready is
//                                    combinational: !main_valid | out_ready.
//
// Parameters:
//   DATA_W    payload width in bits
//   CNT_W     stall counter width
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-low reset
//   flush      in   synchronous flush, kills all held entries
//   in_valid   in   upstream entry present
//   in_ready   out  stage can accept an entry this cycle
//   in_data    in   upstream payload
//   out_valid  out  entry presented downstream (from a flop)
//   out_ready  in   downstream accepts this cycle
//   out_data   out  payload of the head entry (from a flop)
//   occupancy  out  registered count of held entries (0..2)
//   clr_stats  in   synchronous clear of stall_cnt
//   stall_cnt  out  cycles with out_valid=1 and out_ready=0, saturating
// ============================================================================
module pipe_stage_reg #(
   parameter int DATA_W = 256,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   input  logic              clr_stats,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Head register: it drives the downstream side directly.
   logic              mainValid_q, mainValid_d;
   logic [DATA_W-1:0] mainData_q,  mainData_d;

   logic [CNT_W-1:0]  stallCnt_q,  stallCnt_d;

   logic              accept;
   logic              emit;

   // Handshake events for this cycle.
   assign accept = in_valid & in_ready;
   assign emit   = mainValid_q & out_ready;

   assign out_valid = mainValid_q;
   assign out_data  = mainData_q;
   assign stall_cnt = stallCnt_q;

`ifdef PIPE_STAGE_SKID_EN

   // Skid register: catches the entry accepted while the head is stalled.
   logic              skidValid_q, skidValid_d;
   logic [DATA_W-1:0] skidData_q,  skidData_d;

   // Ready depends only on the skid flop, so upstream timing never sees
   // out_ready.
   assign in_ready  = ~skidValid_q;
   assign occupancy = {1'b0, mainValid_q} + {1'b0, skidValid_q};

   // Next-state for the two entries. On emit the skid entry (if any) moves
   // up to the head; a simultaneous accept lands wherever FIFO order puts it.
   // Flush is applied last so it overrides every other valid update. Payloads
   // are left as they are on flush because they are don't-care while invalid.
   always_comb begin
      mainValid_d = mainValid_q;
      mainData_d  = mainData_q;
      skidValid_d = skidValid_q;
      skidData_d  = skidData_q;

      if (emit) begin
         if (skidValid_q) begin
            mainValid_d = 1'b1;
            mainData_d  = skidData_q;
            skidValid_d = accept;
            if (accept) begin
               skidData_d = in_data;
            end
         end else begin
            mainValid_d = accept;
            if (accept) begin
               mainData_d = in_data;
            end
         end
      end else if (accept) begin
         if (mainValid_q) begin
            skidValid_d = 1'b1;
            skidData_d  = in_data;
         end else begin
            mainValid_d = 1'b1;
            mainData_d  = in_data;
         end
      end

      if (flush) begin
         mainValid_d = 1'b0;
         skidValid_d = 1'b0;
      end
   end

   // Skid state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skidValid_q <= 1'b0;
         skidData_q  <= '0;
      end else begin
         skidValid_q <= skidValid_d;
         skidData_q  <= skidData_d;
      end
   end

`else

   // Single-entry build: the head may be refilled in the same cycle it
   // empties, which keeps full throughput at the cost of a combinational
   // ready path.
   assign in_ready  = ~mainValid_q | out_ready;
   assign occupancy = {1'b0, mainValid_q};

   // Next-state for the head entry. An accept always refills it (it is either
   // empty or emptying); otherwise an emit vacates it. Flush overrides.
   always_comb begin
      mainValid_d = mainValid_q;
      mainData_d  = mainData_q;

      if (accept) begin
         mainValid_d = 1'b1;
         mainData_d  = in_data;
      end else if (emit) begin
         mainValid_d = 1'b0;
      end

      if (flush) begin
         mainValid_d = 1'b0;
      end
   end

`endif

   // Head state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mainValid_q <= 1'b0;
         mainData_q  <= '0;
      end else begin
         mainValid_q <= mainValid_d;
         mainData_q  <= mainData_d;
      end
   end

   // Stall counter: counts held-but-not-taken cycles (flush cycles included),
   // sticks at all-ones, and a clear request beats the increment.
   always_comb begin
      stallCnt_d = stallCnt_q;
      if (clr_stats) begin
         stallCnt_d = '0;
      end else if (mainValid_q && !out_ready && (stallCnt_q != CNT_MAX)) begin
         stallCnt_d = stallCnt_q + CNT_ONE;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCnt_q <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
      end
   end

endmodule
